srl_shift_sweep_ctrl: RTL and testbench

Initiator and checker for a bank of NLANES SRLC32E shift registers that share clock, CE, D and address, for example four SRLs placed in one SLICEM's A6LUT–D6LUT.
- Serially shifts a 32-bit pattern into all lanes.
- Sweeps the read address 0..DEPTH-1 and compares each lane's Q against the expected bit.
- Reports pass/fail, error count, failing lanes and first failing address.
- Drives the SRL inputs and consumes the SRL outputs; used in SRL fuzzers and hardware minitests.

---
 rtl/srl_shift_sweep_ctrl_pkg.sv | 25 ++
 rtl/srl_shift_sweep_ctrl_if.sv | 36 +++
 rtl/srl_shift_sweep_ctrl_rd_pipe.sv | 36 +++
 rtl/srl_shift_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_srl_shift_sweep_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srl_shift_sweep_ctrl_pkg.sv
// Shared types and helpers for the SRL shift/sweep test controller.
package srl_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_SWEEP,
      ST_DRAIN,
      ST_FIN
   } state_t;

   localparam int unsigned DEF_DEPTH = 32;
   localparam int unsigned DEF_AW    = 5;
   localparam int unsigned MAX_LANES = 32;

   function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/srl_shift_sweep_ctrl_if.sv
// Request/result and SRL-bank signals of the shift/sweep controller.
interface srl_shift_sweep_ctrl_if
   import srl_test_pkg::*;
#(
   parameter int unsigned NLANES = 4,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned ECW    = 8
) ();

   logic              start;
   logic [DEPTH-1:0]  pattern;
   logic              srl_ce;
   logic              srl_d;
   logic [AW-1:0]     srl_a;
   logic [NLANES-1:0] srl_q;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ECW-1:0]    err_count;
   logic [NLANES-1:0] fail_lanes;
   logic [AW-1:0]     first_fail_addr;

   modport slave (
      input  start, pattern, srl_q,
      output srl_ce, srl_d, srl_a, busy, done, pass,
             err_count, fail_lanes, first_fail_addr
   );

   modport master (
      output start, pattern, srl_q,
      input  srl_ce, srl_d, srl_a, busy, done, pass,
             err_count, fail_lanes, first_fail_addr
   );

endinterface

// File: rtl/srl_shift_sweep_ctrl_rd_pipe.sv
// RD_LAT-deep {valid, addr} delay line matching the SRL read path latency.
module srl_rd_pipe #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   logic          vld [RD_LAT];
   logic [AW-1:0] adr [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            vld[i] <= 1'b0;
            adr[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_addr;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
            adr[i] <= adr[i-1];
         end
      end
   end

   assign out_valid = vld[RD_LAT-1];
   assign out_addr  = adr[RD_LAT-1];

endmodule

// File: rtl/srl_shift_sweep_ctrl.sv
// Loads a pattern into a bank of SRLC32E lanes, sweeps every address and
// checks each lane's output against the pattern.
module srl_shift_sweep_ctrl
   import srl_test_pkg::*;
#(
   parameter int unsigned NLANES = 4,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned ECW    = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   srl_shift_sweep_ctrl_if.slave bus
);

   state_t            state, state_d;
   logic [AW-1:0]     cnt, cnt_d;
   logic [DEPTH-1:0]  pat_q;
   logic              ce_q, ce_d, d_q, d_d;
   logic [AW-1:0]     a_q, a_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic              push;
   logic              accept;
   logic              cmp_vld;
   logic [AW-1:0]     cmp_addr;
   logic [NLANES-1:0] mism;
   logic [ECW-1:0]    err_q;
   logic [NLANES-1:0] lanes_q;
   logic [AW-1:0]     ffa_q;

   assign accept = (state == ST_IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         ce_q   <= 1'b0;
         d_q    <= 1'b0;
         a_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         ce_q   <= ce_d;
         d_q    <= d_d;
         a_q    <= a_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      ce_d    = 1'b0;
      d_d     = 1'b0;
      a_d     = '0;
      push    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            // DEPTH == 2**AW, so ~cnt is DEPTH-1-cnt: MSB shifted in first
            ce_d  = 1'b1;
            d_d   = pat_q[~cnt];
            cnt_d = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) state_d = ST_SWEEP;
         end
         ST_SWEEP: begin
            a_d   = cnt;
            push  = 1'b1;
            cnt_d = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cmp_vld && cmp_addr == AW'(DEPTH - 1)) state_d = ST_FIN;
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == '0);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pat_q <= '0;
      else if (accept) pat_q <= bus.pattern;
   end

   srl_rd_pipe #(
      .RD_LAT (RD_LAT),
      .AW     (AW)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (push),
      .in_addr   (a_d),
      .out_valid (cmp_vld),
      .out_addr  (cmp_addr)
   );

   always_comb begin
      mism = bus.srl_q ^ {NLANES{pat_q[cmp_addr]}};
   end

   // An empty fail mask means no earlier sample of this run has mismatched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= '0;
         lanes_q <= '0;
         ffa_q   <= '0;
      end else if (accept) begin
         err_q   <= '0;
         lanes_q <= '0;
         ffa_q   <= '0;
      end else if (cmp_vld) begin
         err_q   <= err_q + ECW'(popcount(MAX_LANES'(mism)));
         lanes_q <= lanes_q | mism;
         if (mism != '0 && lanes_q == '0) ffa_q <= cmp_addr;
      end
   end

   assign bus.srl_ce          = ce_q;
   assign bus.srl_d           = d_q;
   assign bus.srl_a           = a_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.pass            = pass_q;
   assign bus.err_count       = err_q;
   assign bus.fail_lanes      = lanes_q;
   assign bus.first_fail_addr = ffa_q;

endmodule

// File: tb/tb_srl_shift_sweep_ctrl.sv
// Bench for srl_shift_sweep_ctrl: behavioural SRLC32E lanes with fault
// injection, an RD_LAT=1 and an RD_LAT=2 controller, and a result scoreboard.
module tb_srl_shift_sweep_ctrl;

   localparam int NL   = 4;
   localparam int DP   = 32;
   localparam int AWD  = 5;
   localparam int ECWD = 8;

   typedef struct {
      int unsigned     t_done;
      logic            pass;
      logic [ECWD-1:0] err;
      logic [NL-1:0]   lanes;
      logic [AWD-1:0]  ffa;
      logic [DP-1:0]   pat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_cmp = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   srl_shift_sweep_ctrl_if #(.NLANES(NL), .DEPTH(DP), .AW(AWD), .ECW(ECWD)) bus0 ();
   srl_shift_sweep_ctrl_if #(.NLANES(NL), .DEPTH(DP), .AW(AWD), .ECW(ECWD)) bus1 ();

   srl_shift_sweep_ctrl #(.NLANES(NL), .DEPTH(DP), .AW(AWD), .RD_LAT(1), .ECW(ECWD)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   srl_shift_sweep_ctrl #(.NLANES(NL), .DEPTH(DP), .AW(AWD), .RD_LAT(2), .ECW(ECWD)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   // SRL bank models; lane faults apply to the combinational Q path.
   logic [DP-1:0]  sr0 [NL];
   logic [DP-1:0]  sr1 [NL];
   logic [NL-1:0]  stuck, inv_lanes;
   logic [AWD-1:0] inv_addr;
   logic           qreg0;
   logic [NL-1:0]  qc0, qc1, qr0, qr1;

   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (bus0.srl_ce) sr0[i] <= {sr0[i][DP-2:0], bus0.srl_d};
         if (bus1.srl_ce) sr1[i] <= {sr1[i][DP-2:0], bus1.srl_d};
      end
      qr0 <= qc0;
      qr1 <= qc1;
   end

   always_comb begin
      qc0 = '0;
      qc1 = '0;
      for (int i = 0; i < NL; i++) begin
         qc0[i] = (sr0[i][bus0.srl_a] ^ (inv_lanes[i] && bus0.srl_a == inv_addr)) | stuck[i];
         qc1[i] = (sr1[i][bus1.srl_a] ^ (inv_lanes[i] && bus1.srl_a == inv_addr)) | stuck[i];
      end
   end

   assign bus0.srl_q = qreg0 ? qr0 : qc0;
   assign bus1.srl_q = qr1;

   exp_t          q0[$];
   exp_t          q1[$];
   logic [DP-1:0] dlog0, dlog1;
   int            ce0, ce1;

   // skew: Q is one cycle later than the controller assumes, so address a
   // sees the value presented for a-1 (address 0 sees a one-short shift).
   function automatic exp_t predict(input logic [DP-1:0] p, input int unsigned t0,
                                    input int unsigned lat, input bit skew);
      exp_t e;
      int   n;
      e.pat    = p;
      e.t_done = t0 + 2 * DP + lat + 1;
      e.lanes  = '0;
      e.ffa    = '0;
      n        = 0;
      for (int a = 0; a < DP; a++) begin
         logic [NL-1:0] mm;
         logic          val, obs;
         int            srca;
         mm = '0;
         if (!skew) begin val = p[a]; srca = a; end
         else if (a == 0) begin val = p[1]; srca = 0; end
         else begin val = p[a-1]; srca = a - 1; end
         for (int i = 0; i < NL; i++) begin
            obs = (val ^ (inv_lanes[i] && srca == int'(inv_addr))) | stuck[i];
            mm[i] = (obs != p[a]);
            if (mm[i]) n++;
         end
         if (mm != '0 && e.lanes == '0) e.ffa = AWD'(a);
         e.lanes = e.lanes | mm;
      end
      e.err  = ECWD'(n);
      e.pass = (n == 0);
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (bus0.srl_ce) begin dlog0 = {dlog0[DP-2:0], bus0.srl_d}; ce0++; end
      if (bus0.done) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL done0_unexpected: DONE at cycle %0d, required none", cyc);
         end else begin
            e = q0.pop_front();
            if (cyc !== e.t_done) begin n_fail++; $display("FAIL done0_cycle: got %0d required %0d", cyc, e.t_done); end
            n_cmp++; if (bus0.pass !== e.pass) begin n_fail++; $display("FAIL pass0: got %b required %b", bus0.pass, e.pass); end
            n_cmp++; if (bus0.err_count !== e.err) begin n_fail++; $display("FAIL err_count0: got %0d required %0d", bus0.err_count, e.err); end
            n_cmp++; if (bus0.fail_lanes !== e.lanes) begin n_fail++; $display("FAIL fail_lanes0: got %b required %b", bus0.fail_lanes, e.lanes); end
            n_cmp++; if (bus0.first_fail_addr !== e.ffa) begin n_fail++; $display("FAIL first_fail0: got %0d required %0d", bus0.first_fail_addr, e.ffa); end
            n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done0: got %b required 0", bus0.busy); end
            n_cmp++; if (ce0 !== DP) begin n_fail++; $display("FAIL ce_cycles0: got %0d required %0d", ce0, DP); end
            n_cmp++; if (dlog0 !== e.pat) begin n_fail++; $display("FAIL d_stream0: got %h required %h", dlog0, e.pat); end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus1.srl_ce) begin dlog1 = {dlog1[DP-2:0], bus1.srl_d}; ce1++; end
      if (bus1.done) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL done1_unexpected: DONE at cycle %0d, required none", cyc);
         end else begin
            e = q1.pop_front();
            if (cyc !== e.t_done) begin n_fail++; $display("FAIL done1_cycle: got %0d required %0d", cyc, e.t_done); end
            n_cmp++; if (bus1.pass !== e.pass) begin n_fail++; $display("FAIL pass1: got %b required %b", bus1.pass, e.pass); end
            n_cmp++; if (bus1.err_count !== e.err) begin n_fail++; $display("FAIL err_count1: got %0d required %0d", bus1.err_count, e.err); end
            n_cmp++; if (bus1.fail_lanes !== e.lanes) begin n_fail++; $display("FAIL fail_lanes1: got %b required %b", bus1.fail_lanes, e.lanes); end
            n_cmp++; if (dlog1 !== e.pat) begin n_fail++; $display("FAIL d_stream1: got %h required %h", dlog1, e.pat); end
         end
      end
   end

   task automatic launch(input int inst, input logic [DP-1:0] p, input int unsigned lat, input bit skew);
      @(negedge clk);
      if (inst == 0) begin
         bus0.start = 1'b1; bus0.pattern = p; dlog0 = '0; ce0 = 0;
         q0.push_back(predict(p, cyc + 1, lat, skew));
      end else begin
         bus1.start = 1'b1; bus1.pattern = p; dlog1 = '0; ce1 = 0;
         q1.push_back(predict(p, cyc + 1, lat, skew));
      end
      @(negedge clk);
      bus0.start = 1'b0; bus1.start = 1'b0;
      bus0.pattern = ~p; bus1.pattern = ~p;
   endtask

   task automatic wait_drain(input int inst);
      int k;
      k = 0;
      while (((inst == 0) ? q0.size() : q1.size()) != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k >= 200) begin
         n_fail++;
         $display("FAIL timeout%0d: no DONE within %0d cycles, required one", inst, k);
         if (inst == 0) q0.delete(); else q1.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.start = 1'b0; bus1.start = 1'b0;
      bus0.pattern = '0; bus1.pattern = '0;
      stuck = '0; inv_lanes = '0; inv_addr = '0; qreg0 = 1'b0;
      #1;
      n_cmp++;
      if ({bus0.srl_ce, bus0.srl_d, bus0.srl_a, bus0.busy, bus0.done, bus0.pass} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctl0: got ce=%b d=%b a=%0d busy=%b done=%b pass=%b required all 0",
                  bus0.srl_ce, bus0.srl_d, bus0.srl_a, bus0.busy, bus0.done, bus0.pass);
      end
      n_cmp++;
      if ({bus0.err_count, bus0.fail_lanes, bus0.first_fail_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_stat0: got err=%0d lanes=%b ffa=%0d required 0", bus0.err_count, bus0.fail_lanes, bus0.first_fail_addr);
      end
      n_cmp++;
      if ({bus1.srl_ce, bus1.busy, bus1.done, bus1.pass, bus1.err_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_1: got ce=%b busy=%b done=%b pass=%b err=%0d required 0",
                  bus1.srl_ce, bus1.busy, bus1.done, bus1.pass, bus1.err_count);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_pattern();
      launch(0, 32'h0000_0000, 1, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_run: got %b required 1", bus0.busy); end
      wait_drain(0);
   endtask

   task automatic test_alt_pattern();
      launch(0, 32'hA5A5_F00F, 1, 1'b0);
      wait_drain(0);
   endtask

   task automatic test_stuck_lane();
      stuck = 4'b0100;
      launch(0, 32'h0000_0000, 1, 1'b0);
      wait_drain(0);
      stuck = '0;
   endtask

   task automatic test_single_flip();
      inv_lanes = 4'b0001; inv_addr = 5'd17;
      launch(0, 32'hFFFF_FFFF, 1, 1'b0);
      wait_drain(0);
      inv_lanes = '0; inv_addr = '0;
   endtask

   task automatic test_abort_and_ignore();
      int k;
      launch(0, 32'h1234_5678, 1, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus0.srl_ce !== 1'b0 || bus0.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: got ce=%b busy=%b required 0 0", bus0.srl_ce, bus0.busy);
      end
      q0.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      launch(0, 32'h0F0F_3C3C, 1, 1'b0);
      repeat (40) @(negedge clk);
      bus0.start = 1'b1; bus0.pattern = 32'hDEAD_BEEF;
      @(negedge clk);
      bus0.start = 1'b0;
      k = 0;
      while (q0.size() != 0 && cyc + 1 < q0[0].t_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      wait_drain(0);
      repeat (80) @(negedge clk);
      n_cmp++;
      if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_busy: got %b required 0", bus0.busy); end
   endtask

   task automatic test_rd_lat();
      launch(1, 32'hA5A5_F00F, 2, 1'b0);
      wait_drain(1);
      qreg0 = 1'b1;
      launch(0, 32'hA5A5_F00F, 1, 1'b1);
      wait_drain(0);
      qreg0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_pattern();
      test_alt_pattern();
      test_stuck_lane();
      test_single_flip();
      test_abort_and_ignore();
      test_rd_lat();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
